// File: rtl/mrelbp_r2_window_feeder_pkg.sv
// Shared constants and state encoding for the MRELBP CI R2 window feeder.
// The window height sets both the number of line buffers and the output column width.
package mrelbp_r2_window_feeder_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_H = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/mrelbp_r2_window_feeder_if.sv
// Pixel-in / column-out bundle between the pixel source and the CI R2 stage.
// The feeder sits on the slave side: it takes pixels and produces the S1..S5 columns.
interface mrelbp_r2_window_feeder_if;
    import mrelbp_r2_window_feeder_pkg::*;

    logic             sof_i;
    logic             done_i;
    logic [PIX_W-1:0] data_i;
    logic [PIX_W-1:0] S1;
    logic [PIX_W-1:0] S2;
    logic [PIX_W-1:0] S3;
    logic [PIX_W-1:0] S4;
    logic [PIX_W-1:0] S5;
    logic             done_o;
    logic             progress_done_o;

    modport master (
        output sof_i, done_i, data_i,
        input  S1, S2, S3, S4, S5, done_o, progress_done_o
    );

    modport slave (
        input  sof_i, done_i, data_i,
        output S1, S2, S3, S4, S5, done_o, progress_done_o
    );

endinterface

// File: rtl/mrelbp_r2_window_feeder_r2_line_buffer.sv
// One image-row delay line: q is the pixel accepted exactly DEPTH enabled shifts ago.
// Contents are cleared on reset only so simulation starts deterministic; the fill phase rewrites them.
module r2_line_buffer
    import mrelbp_r2_window_feeder_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] q
);

    logic [DEPTH-1:0][PIX_W-1:0] r_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else if (en) begin
            r_sr <= {r_sr[DEPTH-2:0], d};
        end
    end

    assign q = r_sr[DEPTH-1];

endmodule

// File: rtl/mrelbp_r2_window_feeder.sv
// Turns a raster pixel stream into 5-row vertical columns for the MRELBP CI R2 stage.
// Rows 0..3 only prime the line buffers; every pixel from row 4 on yields one column a cycle later.
module mrelbp_r2_window_feeder
    import mrelbp_r2_window_feeder_pkg::*;
#(
    parameter int COLS = 7,
    parameter int ROWS = 7
) (
    input logic                      clk,
    input logic                      rst,
    mrelbp_r2_window_feeder_if.slave bus
);

    localparam int CW            = $clog2(COLS);
    localparam int RW            = $clog2(ROWS);
    localparam int NBUF          = WIN_H - 1;
    localparam int LAST_FILL_ROW = WIN_H - 2;

    state_t                      r_state, w_stateNext;
    logic [CW-1:0]               r_colCnt, w_colNext, w_effCol;
    logic [RW-1:0]               r_rowCnt, w_rowNext, w_effRow;
    logic                        w_emit, w_last;
    logic [WIN_H-1:0][PIX_W-1:0] w_chain;
    logic [WIN_H-1:0][PIX_W-1:0] r_s;
    logic                        r_doneO, r_progress;

    // w_chain[WIN_H-1] is the live pixel; w_chain[0] is the oldest row (r-4).
    assign w_chain[WIN_H-1] = bus.data_i;

    genvar k;
    generate
        for (k = 0; k < NBUF; k++) begin : g_lb
            r2_line_buffer #(.DEPTH(COLS)) u_lb (
                .clk (clk),
                .rst (rst),
                .en  (bus.done_i),
                .d   (w_chain[k+1]),
                .q   (w_chain[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_colCnt <= '0;
            r_rowCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_colCnt <= w_colNext;
            r_rowCnt <= w_rowNext;
        end
    end

    // A start-of-frame pixel, or the first pixel seen in IDLE, is always row 0 / col 0.
    always_comb begin
        w_stateNext = r_state;
        w_colNext   = r_colCnt;
        w_rowNext   = r_rowCnt;
        w_effCol    = r_colCnt;
        w_effRow    = r_rowCnt;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        if (bus.done_i) begin
            if (bus.sof_i || r_state == IDLE) begin
                w_effCol = '0;
                w_effRow = '0;
            end
            w_emit = (r_state == STREAM) && !bus.sof_i;
            if (w_effCol == CW'(COLS - 1)) begin
                w_colNext = '0;
                if (w_effRow == RW'(ROWS - 1)) begin
                    w_rowNext   = '0;
                    w_stateNext = IDLE;
                    w_last      = w_emit;
                end else begin
                    w_rowNext   = w_effRow + RW'(1);
                    w_stateNext = (w_effRow == RW'(LAST_FILL_ROW)) ? STREAM : FILL;
                    if (w_effRow > RW'(LAST_FILL_ROW)) w_stateNext = STREAM;
                end
            end else begin
                w_colNext = w_effCol + CW'(1);
                w_rowNext = w_effRow;
                if (bus.sof_i || r_state == IDLE) w_stateNext = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s        <= '0;
            r_doneO    <= 1'b0;
            r_progress <= 1'b0;
        end else begin
            r_doneO    <= w_emit;
            r_progress <= w_last;
            if (w_emit) r_s <= w_chain;
        end
    end

    assign bus.S1              = r_s[0];
    assign bus.S2              = r_s[1];
    assign bus.S3              = r_s[2];
    assign bus.S4              = r_s[3];
    assign bus.S5              = r_s[4];
    assign bus.done_o          = r_doneO;
    assign bus.progress_done_o = r_progress;

endmodule

// File: tb/tb_mrelbp_r2_window_feeder.sv
// Directed bench for the R2 window feeder: vector tables built from a row/col pixel model,
// plus hand-written reset sequences.
module tb_mrelbp_r2_window_feeder;

    localparam int COLS = 7;
    localparam int ROWS = 7;

    typedef struct {
        logic        sof;
        logic        done;
        logic [7:0]  data;
        logic        expDone;
        logic        expProg;
        logic [39:0] expS;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mrelbp_r2_window_feeder_if bus ();

    mrelbp_r2_window_feeder #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t        vecs[$];
    logic [39:0] mS;
    int          nChecks = 0;
    int          nPass   = 0;
    int          pulses;
    int          progs;

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
        return base + 8'(r * 16 + c);
    endfunction

    function automatic logic [41:0] observed();
        return {bus.done_o, bus.progress_done_o, bus.S1, bus.S2, bus.S3, bus.S4, bus.S5};
    endfunction

    task automatic checkOutput(input string name, input logic [41:0] got, input logic [41:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("[TB] FAIL %s: got done/prog/S=%h required %h", name, got, exp);
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    task automatic addGap();
        vec_t v;
        v.sof = 1'b0; v.done = 1'b0; v.data = 8'h00;
        v.expDone = 1'b0; v.expProg = 1'b0; v.expS = mS;
        vecs.push_back(v);
    endtask

    // Append nPix pixels of a frame whose pixel (r,c) is base+r*16+c.
    task automatic addFrame(input logic [7:0] base, input bit firstSof, input int nPix, input bit gaps);
        vec_t v;
        for (int i = 0; i < nPix; i++) begin
            int r = i / COLS;
            int c = i % COLS;
            v.sof  = firstSof && (i == 0);
            v.done = 1'b1;
            v.data = pix(base, r, c);
            if (r >= 4) begin
                mS = {pix(base, r-4, c), pix(base, r-3, c), pix(base, r-2, c),
                      pix(base, r-1, c), pix(base, r, c)};
                v.expDone = 1'b1;
                v.expProg = (r == ROWS - 1) && (c == COLS - 1);
            end else begin
                v.expDone = 1'b0;
                v.expProg = 1'b0;
            end
            v.expS = mS;
            vecs.push_back(v);
            if (gaps) addGap();
        end
    endtask

    task automatic applyStimulus(input string label, output int nPulse, output int nProg);
        nPulse = 0;
        nProg  = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.sof_i  = vecs[i].sof;
            bus.done_i = vecs[i].done;
            bus.data_i = vecs[i].data;
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1) nPulse++;
            if (bus.progress_done_o === 1'b1) nProg++;
            checkOutput($sformatf("%s_v%0d", label, i), observed(),
                        {vecs[i].expDone, vecs[i].expProg, vecs[i].expS});
        end
        bus.sof_i  = 1'b0;
        bus.done_i = 1'b0;
        bus.data_i = 8'h00;
        vecs.delete();
    endtask

    initial begin
        bus.sof_i  = 1'b0;
        bus.done_i = 1'b0;
        bus.data_i = 8'h00;
        mS = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", observed(), 42'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 100; i++) addGap();
        applyStimulus("idle", pulses, progs);
        checkCount("idle_pulses", pulses, 0);

        addFrame(8'h00, 1'b1, ROWS * COLS, 1'b0);
        applyStimulus("frame", pulses, progs);
        checkCount("frame_pulses", pulses, 21);
        checkCount("frame_progress", progs, 1);

        addFrame(8'h00, 1'b0, ROWS * COLS, 1'b1);
        applyStimulus("gapped", pulses, progs);
        checkCount("gapped_pulses", pulses, 21);
        checkCount("gapped_progress", progs, 1);

        addFrame(8'h00, 1'b0, ROWS * COLS, 1'b0);
        addFrame(8'h80, 1'b0, ROWS * COLS, 1'b0);
        applyStimulus("b2b", pulses, progs);
        checkCount("b2b_pulses", pulses, 42);
        checkCount("b2b_progress", progs, 2);

        // Restart at row 5 col 3: 10 columns of the old frame, then a full new frame.
        addFrame(8'h00, 1'b0, 5 * COLS + 3, 1'b0);
        addFrame(8'h80, 1'b1, ROWS * COLS, 1'b0);
        applyStimulus("sof_restart", pulses, progs);
        checkCount("sof_restart_pulses", pulses, 31);
        checkCount("sof_restart_progress", progs, 1);

        // Reset three pixels into row 4; outputs must clear without waiting for a clock edge.
        addFrame(8'h00, 1'b0, 4 * COLS + 3, 1'b0);
        applyStimulus("pre_reset", pulses, progs);
        checkCount("pre_reset_pulses", pulses, 3);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", observed(), 42'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mS  = '0;

        addFrame(8'h40, 1'b0, ROWS * COLS, 1'b0);
        applyStimulus("post_reset", pulses, progs);
        checkCount("post_reset_pulses", pulses, 21);
        checkCount("post_reset_progress", progs, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running required finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
